// File: rtl/lcd_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_spi_rx
// Description : Oversampling receiver for an ST7735-style 4-wire LCD SPI link.
//               Decodes command/parameter bytes, tracks the CASET/RASET
//               address window and emits one strobe per RGB565 pixel written
//               during RAMWR, tagged with its column and row.
//               Optional feature macro: LCD_RX_MADCTL_EN (MADCTL MV bit,
//               row-first address advance).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_spi_rx #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_clk,
   input  logic        spi_mosi,
   input  logic        spi_dc,
   input  logic        spi_cs,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic        pix_valid,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic [15:0] pix_data,
   output logic        frame_done,
   output logic        in_ramwr
);

`ifdef LCD_RX_MADCTL_EN
   localparam logic MADCTL_EN = 1'b1;
`else
   localparam logic MADCTL_EN = 1'b0;
`endif

   localparam logic [7:0] XE_DEF = 8'(WIDTH - 1);
   localparam logic [7:0] YE_DEF = 8'(HEIGHT - 1);

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_RASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PARAM  = 3'd1,
      S_PIX_HI = 3'd2,
      S_PIX_LO = 3'd3,
      S_IGNORE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      T_CASET  = 2'd0,
      T_RASET  = 2'd1,
      T_MADCTL = 2'd2
   } target_t;

   // ------------------------------------------------------------------------
   // Input synchronizers and byte shifter
   // ------------------------------------------------------------------------
   logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic       mosi_meta_q, mosi_sync_q;
   logic       dc_meta_q,   dc_sync_q;
   logic       cs_meta_q,   cs_sync_q;
   logic [6:0] shift_q;
   logic [2:0] bitcnt_q;

   logic       w_sclk_rise;
   logic       w_shift_en;
   logic       w_byte_stb;
   logic [7:0] w_byte;
   logic       w_byte_dc;

   // Two-flop synchronizers; clock and CS come out of reset at their idle
   // (high) level so releasing reset never looks like a rising edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_meta_q <= 1'b1;
         sclk_sync_q <= 1'b1;
         sclk_prev_q <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         dc_meta_q   <= 1'b0;
         dc_sync_q   <= 1'b0;
         cs_meta_q   <= 1'b1;
         cs_sync_q   <= 1'b1;
      end else begin
         sclk_meta_q <= spi_clk;
         sclk_sync_q <= sclk_meta_q;
         sclk_prev_q <= sclk_sync_q;
         mosi_meta_q <= spi_mosi;
         mosi_sync_q <= mosi_meta_q;
         dc_meta_q   <= spi_dc;
         dc_sync_q   <= dc_meta_q;
         cs_meta_q   <= spi_cs;
         cs_sync_q   <= cs_meta_q;
      end
   end

   assign w_sclk_rise = sclk_sync_q & ~sclk_prev_q;
   assign w_shift_en  = w_sclk_rise & ~cs_sync_q;
   // The 8th bit completes the byte combinationally so the decoder can
   // register its strobes one cycle after the synchronized edge.
   assign w_byte_stb  = w_shift_en & (bitcnt_q == 3'd7);
   assign w_byte      = {shift_q, mosi_sync_q};
   assign w_byte_dc   = dc_sync_q;

   // Shift MOSI on each selected rising edge; CS high discards a partial byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q  <= 7'd0;
         bitcnt_q <= 3'd0;
      end else if (cs_sync_q) begin
         bitcnt_q <= 3'd0;
      end else if (w_shift_en) begin
         shift_q  <= {shift_q[5:0], mosi_sync_q};
         bitcnt_q <= bitcnt_q + 3'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Command decoder, window registers and address pointer
   // ------------------------------------------------------------------------
   state_t     state_q, state_d;
   target_t    tgt_q, tgt_d;
   logic [1:0] idx_q, idx_d;
   logic [7:0] pstart_q, pstart_d;
   logic [7:0] xs_q, xs_d, xe_q, xe_d;
   logic [7:0] ys_q, ys_d, ye_q, ye_d;
   logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [7:0] pix_hi_q, pix_hi_d;
   logic       mv_q, mv_d;

   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic        pix_valid_q, pix_valid_d;
   logic [7:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [15:0] pix_data_q, pix_data_d;
   logic        frame_done_q, frame_done_d;

   logic [7:0] w_adv_x, w_adv_y;
   logic       w_adv_frame;

   // Next pointer position; start acts as the wrap target and only an exact
   // match with end wraps, so a start > end window still behaves defined.
   always_comb begin
      w_adv_x     = cur_x_q;
      w_adv_y     = cur_y_q;
      w_adv_frame = 1'b0;
      if (!mv_q) begin
         if (cur_x_q == xe_q) begin
            w_adv_x = xs_q;
            if (cur_y_q == ye_q) begin
               w_adv_y     = ys_q;
               w_adv_frame = 1'b1;
            end else begin
               w_adv_y = cur_y_q + 8'd1;
            end
         end else begin
            w_adv_x = cur_x_q + 8'd1;
         end
      end else begin
         if (cur_y_q == ye_q) begin
            w_adv_y = ys_q;
            if (cur_x_q == xe_q) begin
               w_adv_x     = xs_q;
               w_adv_frame = 1'b1;
            end else begin
               w_adv_x = cur_x_q + 8'd1;
            end
         end else begin
            w_adv_y = cur_y_q + 8'd1;
         end
      end
   end

   // Decoder next-state: commands restart from any state, data bytes are
   // interpreted according to the current state.
   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      idx_d        = idx_q;
      pstart_d     = pstart_q;
      xs_d         = xs_q;
      xe_d         = xe_q;
      ys_d         = ys_q;
      ye_d         = ye_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      pix_hi_d     = pix_hi_q;
      mv_d         = mv_q;
      cmd_valid_d  = 1'b0;
      cmd_code_d   = cmd_code_q;
      pix_valid_d  = 1'b0;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_data_d   = pix_data_q;
      frame_done_d = 1'b0;

      if (w_byte_stb) begin
         if (!w_byte_dc) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = w_byte;
            idx_d       = 2'd0;
            if (w_byte == CMD_CASET) begin
               state_d = S_PARAM;
               tgt_d   = T_CASET;
            end else if (w_byte == CMD_RASET) begin
               state_d = S_PARAM;
               tgt_d   = T_RASET;
            end else if (w_byte == CMD_RAMWR) begin
               state_d = S_PIX_HI;
               cur_x_d = xs_q;
               cur_y_d = ys_q;
            end else if (w_byte == CMD_SWRESET) begin
               state_d = S_IDLE;
               xs_d    = 8'd0;
               xe_d    = XE_DEF;
               ys_d    = 8'd0;
               ye_d    = YE_DEF;
            end else if (MADCTL_EN && (w_byte == CMD_MADCTL)) begin
               state_d = S_PARAM;
               tgt_d   = T_MADCTL;
            end else begin
               state_d = S_IGNORE;
            end
         end else begin
            case (state_q)
               S_PARAM: begin
                  if (tgt_q == T_MADCTL) begin
                     mv_d    = w_byte[5];
                     state_d = S_IDLE;
                  end else begin
                     idx_d = idx_q + 2'd1;
                     // High bytes (idx 0 and 2) are dropped: coordinates are 8-bit.
                     if (idx_q == 2'd1) begin
                        pstart_d = w_byte;
                     end else if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        if (tgt_q == T_CASET) begin
                           xs_d = pstart_q;
                           xe_d = w_byte;
                        end else begin
                           ys_d = pstart_q;
                           ye_d = w_byte;
                        end
                     end
                  end
               end
               S_PIX_HI: begin
                  pix_hi_d = w_byte;
                  state_d  = S_PIX_LO;
               end
               S_PIX_LO: begin
                  pix_valid_d  = 1'b1;
                  pix_x_d      = cur_x_q;
                  pix_y_d      = cur_y_q;
                  pix_data_d   = {pix_hi_q, w_byte};
                  frame_done_d = w_adv_frame;
                  cur_x_d      = w_adv_x;
                  cur_y_d      = w_adv_y;
                  state_d      = S_PIX_HI;
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end
   end

   // Decoder state, window, pointer and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         tgt_q        <= T_CASET;
         idx_q        <= 2'd0;
         pstart_q     <= 8'd0;
         xs_q         <= 8'd0;
         xe_q         <= XE_DEF;
         ys_q         <= 8'd0;
         ye_q         <= YE_DEF;
         cur_x_q      <= 8'd0;
         cur_y_q      <= 8'd0;
         pix_hi_q     <= 8'd0;
         mv_q         <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_code_q   <= 8'd0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= 8'd0;
         pix_y_q      <= 8'd0;
         pix_data_q   <= 16'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         idx_q        <= idx_d;
         pstart_q     <= pstart_d;
         xs_q         <= xs_d;
         xe_q         <= xe_d;
         ys_q         <= ys_d;
         ye_q         <= ye_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         pix_hi_q     <= pix_hi_d;
         mv_q         <= mv_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_code_q   <= cmd_code_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_data_q   <= pix_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_code   = cmd_code_q;
   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_data   = pix_data_q;
   assign frame_done = frame_done_q;
   assign in_ramwr   = (state_q == S_PIX_HI) || (state_q == S_PIX_LO);

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_spi_rx
// Description : Directed self-checking bench for lcd_spi_rx. Strobes are
//               captured into queues on the falling clock edge and compared
//               against hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_clk, spi_mosi, spi_dc, spi_cs;
   logic        cmd_valid, pix_valid, frame_done, in_ramwr;
   logic [7:0]  cmd_code, pix_x, pix_y;
   logic [15:0] pix_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  cmd_seen[$];
   logic [32:0] pix_seen[$];
   logic [32:0] pix_exp[$];

   lcd_spi_rx #(.WIDTH(160), .HEIGHT(80)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_dc     (spi_dc),
      .spi_cs     (spi_cs),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .pix_valid  (pix_valid),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_data   (pix_data),
      .frame_done (frame_done),
      .in_ramwr   (in_ramwr)
   );

   always #5 clk = ~clk;

   // Capture strobes away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid) cmd_seen.push_back(cmd_code);
         if (pix_valid) pix_seen.push_back({frame_done, pix_x, pix_y, pix_data});
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, need completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, need 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input logic dc);
      spi_clk  = 1'b0;
      spi_mosi = b;
      spi_dc   = dc;
      wait_clk(2);
      spi_clk = 1'b1;
      wait_clk(2);
   endtask

   task automatic send_byte(input logic dc, input logic [7:0] b);
      spi_cs = 1'b0;
      for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
   endtask

   task automatic cmd(input logic [7:0] c);
      send_byte(1'b0, c);
   endtask

   task automatic dat(input logic [7:0] d);
      send_byte(1'b1, d);
   endtask

   task automatic pixel(input logic [15:0] p);
      dat(p[15:8]);
      dat(p[7:0]);
   endtask

   task automatic set_window(input logic [7:0] xs, xe, ys, ye);
      cmd(8'h2A); dat(8'h00); dat(xs); dat(8'h00); dat(xe);
      cmd(8'h2B); dat(8'h00); dat(ys); dat(8'h00); dat(ye);
   endtask

   task automatic exp_pix(input logic [7:0] x, y, input logic [15:0] d, input logic fd);
      pix_exp.push_back({fd, x, y, d});
   endtask

   task automatic clear_q();
      cmd_seen.delete();
      pix_seen.delete();
      pix_exp.delete();
   endtask

   // Compare captured pixels against the expectation queue.
   task automatic compare_pix(input string tag);
      check({tag, "_count"}, pix_seen.size(), pix_exp.size());
      for (int i = 0; i < pix_exp.size() && i < pix_seen.size(); i++) begin
         check($sformatf("%s_pix%0d", tag, i), {pix_seen[i][32], 7'd0, pix_seen[i][31:24],
               pix_seen[i][23:16]}, {pix_exp[i][32], 7'd0, pix_exp[i][31:24], pix_exp[i][23:16]});
         check($sformatf("%s_dat%0d", tag, i), {16'd0, pix_seen[i][15:0]}, {16'd0, pix_exp[i][15:0]});
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_strobes"}, {cmd_valid, pix_valid, frame_done, in_ramwr}, 4'b0000);
      check({tag, "_cmd_code"}, cmd_code, 8'h00);
      check({tag, "_pix_xy"}, {pix_x, pix_y}, 16'h0000);
      check({tag, "_pix_data"}, pix_data, 16'h0000);
   endtask

   initial begin
      reset    = 1'b1;
      spi_clk  = 1'b1;
      spi_mosi = 1'b0;
      spi_dc   = 1'b0;
      spi_cs   = 1'b1;
      wait_clk(4);
      check_idle_outputs("reset");
      reset = 1'b0;
      wait_clk(4);

      // 4x2 window, 9 pixels: raster order, frame_done on the 8th, wrap on the 9th.
      clear_q();
      set_window(8'd0, 8'd3, 8'd0, 8'd1);
      cmd(8'h2C);
      wait_clk(4);
      check("ramwr_level", in_ramwr, 1);
      for (int i = 1; i <= 9; i++) pixel(16'(i));
      wait_clk(6);
      exp_pix(0, 0, 16'h0001, 0); exp_pix(1, 0, 16'h0002, 0);
      exp_pix(2, 0, 16'h0003, 0); exp_pix(3, 0, 16'h0004, 0);
      exp_pix(0, 1, 16'h0005, 0); exp_pix(1, 1, 16'h0006, 0);
      exp_pix(2, 1, 16'h0007, 0); exp_pix(3, 1, 16'h0008, 1);
      exp_pix(0, 0, 16'h0009, 0);
      compare_pix("frame");
      check("frame_cmds", cmd_seen.size(), 3);

      // Unrelated commands with data: codes reported, no pixels, window kept.
      clear_q();
      cmd(8'hB4); dat(8'h07);
      cmd(8'h3A); dat(8'h05);
      wait_clk(6);
      check("other_cmd_cnt", cmd_seen.size(), 2);
      if (cmd_seen.size() == 2) begin
         check("other_cmd0", cmd_seen[0], 8'hB4);
         check("other_cmd1", cmd_seen[1], 8'h3A);
      end
      check("other_in_ramwr", in_ramwr, 0);
      cmd(8'h2C);
      for (int i = 0; i < 5; i++) pixel(16'hA000 + 16'(i));
      wait_clk(6);
      exp_pix(0, 0, 16'hA000, 0); exp_pix(1, 0, 16'hA001, 0);
      exp_pix(2, 0, 16'hA002, 0); exp_pix(3, 0, 16'hA003, 0);
      exp_pix(0, 1, 16'hA004, 0);
      compare_pix("other");

      // High byte, stray partial byte, CS high, then low byte.
      clear_q();
      cmd(8'h2C);
      dat(8'hF8);
      send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b1);
      spi_cs = 1'b1;
      wait_clk(10);
      dat(8'h00);
      wait_clk(6);
      exp_pix(0, 0, 16'hF800, 0);
      compare_pix("stray");

      // Incomplete pixel aborted by a new RAMWR.
      clear_q();
      cmd(8'h2C);
      dat(8'h55);
      cmd(8'h2C);
      pixel(16'h1234);
      wait_clk(6);
      exp_pix(0, 0, 16'h1234, 0);
      compare_pix("abort");

      // SWRESET restores the full-width window.
      clear_q();
      cmd(8'h01);
      wait_clk(4);
      check("swreset_level", in_ramwr, 0);
      cmd(8'h2C);
      for (int i = 0; i < 5; i++) pixel(16'hC000 + 16'(i));
      wait_clk(6);
      for (int i = 0; i < 5; i++) exp_pix(8'(i), 0, 16'hC000 + 16'(i), 0);
      compare_pix("swreset");

      // MADCTL MV=1 over a 2x2 window (column-first when the feature is off).
      clear_q();
      set_window(8'd0, 8'd1, 8'd0, 8'd1);
      cmd(8'h36); dat(8'h20);
      cmd(8'h2C);
      for (int i = 1; i <= 4; i++) pixel(16'hB000 + 16'(i));
      wait_clk(6);
`ifdef LCD_RX_MADCTL_EN
      exp_pix(0, 0, 16'hB001, 0); exp_pix(0, 1, 16'hB002, 0);
      exp_pix(1, 0, 16'hB003, 0); exp_pix(1, 1, 16'hB004, 1);
`else
      exp_pix(0, 0, 16'hB001, 0); exp_pix(1, 0, 16'hB002, 0);
      exp_pix(0, 1, 16'hB003, 0); exp_pix(1, 1, 16'hB004, 1);
`endif
      compare_pix("madctl");

      // Reset mid-pixel with the pointer at (5,3) of an 8x8 window.
      clear_q();
      set_window(8'd0, 8'd7, 8'd0, 8'd7);
      cmd(8'h36); dat(8'h00);
      cmd(8'h2C);
      for (int i = 0; i < 29; i++) pixel(16'(i));
      dat(8'hEE);
      send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
      reset = 1'b1;
      wait_clk(3);
      check_idle_outputs("midreset");
      for (int i = 0; i < 29; i++) exp_pix(8'(i % 8), 8'(i / 8), 16'(i), 0);
      compare_pix("prereset");
      spi_clk = 1'b1;
      spi_cs  = 1'b1;
      wait_clk(2);
      reset = 1'b0;
      wait_clk(4);
      clear_q();
      cmd(8'h2C);
      for (int i = 0; i < 161; i++) pixel(16'h4000 + 16'(i));
      wait_clk(6);
      for (int i = 0; i < 161; i++) exp_pix(8'(i % 160), 8'(i / 160), 16'h4000 + 16'(i), 0);
      compare_pix("postreset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_spi_rx.md
# lcd_spi_rx

SPI receiver for the ST7735-style 4-wire LCD link (SCLK, MOSI, D/C, CS). It sits on the far side of the LCD driver: a display-controller model in simulation, and a loopback/capture block on FPGA. It oversamples the link on the system clock and decodes command and parameter bytes. It tracks the CASET/RASET address window and emits one strobe per RGB565 pixel written during RAMWR, tagged with its column and row.

## Interface
- `WIDTH`, 160: default column count; window end after reset or SWRESET is `WIDTH-1`.
- `HEIGHT`, 80: default row count; window end after reset or SWRESET is `HEIGHT-1`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `spi_clk`  in  1  serial clock from the master; idles high; data sampled on rising edge.
- `spi_mosi`  in  1  serial data, MSB first.
- `spi_dc`  in  1  0 = command byte, 1 = data/parameter byte; sampled with bit 0 of each byte.
- `spi_cs`  in  1  chip select, active-low.
- `cmd_valid`  out  1  one-cycle pulse per received command byte.
- `cmd_code`  out  8  last command byte; valid with `cmd_valid`, held otherwise.
- `pix_valid`  out  1  one-cycle pulse per completed pixel.
- `pix_x`  out  8  column of the pixel; valid with `pix_valid`.
- `pix_y`  out  8  row of the pixel; valid with `pix_valid`.
- `pix_data`  out  16  RGB565 pixel, high byte received first.
- `frame_done`  out  1  pulse coincident with the `pix_valid` at (xe, ye).
- `in_ramwr`  out  1  level; high while RAMWR data is being accepted.

## Operation
- Input sync: `spi_clk`, `spi_mosi`, `spi_dc`, `spi_cs` each pass through a 2-flop synchronizer. Rising edge = synced sclk now 1, previous 0.
- Shifter: on each rising edge with synced CS low, shift MOSI in. On the 8th bit, latch the byte and its D/C flag and raise an internal byte strobe.
- CS high clears the bit counter; a partial byte is discarded. Decoder state and address pointer are kept across CS deassertion.
- Decoder states:
  - IDLE: waiting for a command.
  - PARAM: collecting CASET/RASET parameters, index 0..3.
  - PIX_HI / PIX_LO: receiving RAMWR pixel bytes.
  - IGNORE: any other command.
- Any D/C=0 byte pulses `cmd_valid` and enters a new state from any state, aborting an incomplete pixel or parameter set:
  - 0x2A (CASET) or 0x2B (RASET) -> PARAM, idx 0.
  - 0x2C (RAMWR) -> PIX_HI; pointer set to (xs, ys).
  - 0x01 (SWRESET) -> IDLE; window restored to defaults.
  - Anything else -> IGNORE.
- PARAM bytes: idx0 = start[15:8], idx1 = start[7:0], idx2 = end[15:8], idx3 = end[7:0].
  - Only the low 8 bits are stored.
  - The new window commits only on idx3; then -> IDLE.
  - A window with start > end is stored as-is; the address advance then treats start as the wrap point.
- Data bytes in IDLE or IGNORE are dropped.
- PIX_HI stores the high byte, -> PIX_LO. PIX_LO outputs the pixel at the current pointer, then advances:
  - cur_x == xe: cur_x = xs, row advance.
  - Row advance with cur_y == ye: cur_y = ys, `frame_done`.
  - Otherwise +1 on the axis being advanced.
  - Then -> PIX_HI.
- `in_ramwr` = state in {PIX_HI, PIX_LO}.
- Reset values: all outputs 0; xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1; pointer (0,0); state IDLE; bit counter 0.

## Timing
- `spi_clk` high and low phases must each be at least 2 `clk` cycles (4 `clk` per bit minimum). MOSI and D/C must be stable across the rising edge.
- Latency from the synchronized 8th rising edge to `cmd_valid` or `pix_valid`: 1 cycle. From the raw pin it is ≤ 4 `clk` cycles.
- Strobes are exactly one cycle wide. A strobe can recur no sooner than 32 `clk` cycles, so no back-pressure is needed.
- `pix_x`, `pix_y` and `pix_data` change only with `pix_valid`.
- Asynchronous reset mid-byte or mid-pixel drops the partial data; no strobe is emitted.

## Configuration
- `LCD_RX_MADCTL_EN` defined:
  - Command 0x36 enters PARAM mode for one byte.
  - Parameter bit 5 (MV) is stored.
  - MV=1 swaps the advance order: row advances first, column on row wrap.
  - MV resets to 0.
- Undefined: 0x36 goes to IGNORE; advance is always column-first.

## Test plan
- CASET 00 00 00 03, RASET 00 00 00 01, RAMWR, 8 pixels 0x0001..0x0008 -> `pix_valid` ×8 at (0,0)(1,0)(2,0)(3,0)(0,1)…(3,1); `frame_done` on the 8th; the 9th pixel is at (0,0).
- Command 0xB4 + data 0x07, then 0x3A + 0x05 -> `cmd_valid` ×2 with codes 0xB4, 0x3A; no `pix_valid`; window unchanged.
- RAMWR, high byte 0xF8, then CS high for 10 cycles with 3 stray bits, then low byte 0x00 -> one pixel 0xF800 at (xs, ys); the stray bits are discarded.
- During RAMWR: high byte only, then command 0x2C -> no `pix_valid`; the next pair produces a pixel at (xs, ys).
- Assert `reset` mid-frame at pointer (5,3) -> all outputs 0 and the window at defaults; RAMWR + 1 pixel then lands at (0,0).
- `LCD_RX_MADCTL_EN` defined: 0x36 + 0x20, 2×2 window, 4 pixels -> positions (0,0)(0,1)(1,0)(1,1).
